// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline step controller.
// Holds the FSM state encoding and width, the register-address width and the
// default number of drain steps issued after HALT.
package pipeline_ctrl_pkg;

  localparam int unsigned STATE_W      = 3;
  localparam int unsigned NB_REGS      = 5;
  localparam int unsigned DRAIN_CYCLES = 3;

  typedef enum logic [STATE_W-1:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StDrain  = 3'd3,
    StHalted = 3'd4
  } state_e;

  // States in which the pipeline advances.
  function automatic logic is_active(state_e s);
    return (s == StRun) || (s == StStep) || (s == StDrain);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   mem_read  - instruction in ID/EX is a load
//   id_ex_rt  - load destination register in ID/EX
//   if_id_rs  - first source register of the instruction in IF/ID
//   if_id_rt  - second source register of the instruction in IF/ID
//   stall     - the IF/ID instruction must wait one cycle for the load
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_REGS = pipeline_ctrl_pkg::NB_REGS
) (
  input  logic               mem_read,
  input  logic [NB_REGS-1:0] id_ex_rt,
  input  logic [NB_REGS-1:0] if_id_rs,
  input  logic [NB_REGS-1:0] if_id_rt,
  output logic               stall
);

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    stall = mem_read && (id_ex_rt != '0) &&
            ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Five-stage MIPS pipeline sequencer.
// Generates the PC enable and the IF/ID, ID/EX, EX/MEM, MEM/WB step enables in
// continuous-run or single-step mode, stalls on load-use hazards, flushes IF/ID
// on taken branches/jumps, and drains the pipeline after HALT.
// Enables are a Mealy decode of the registered state and hazard inputs, settled
// before the falling edge on which the pipeline registers sample.
// Ports:
//   i_clk, i_reset_n            - clock (rising edge), async active-low reset
//   i_run, i_step_req           - continuous run level / single-step pulse
//   i_restart                   - leave HALTED back to IDLE
//   i_halt_decoded              - HALT opcode present in IF/ID
//   i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt - load-use inputs
//   i_branch_taken, i_jump      - control transfer resolved in EX
//   o_pc_en, o_step_*           - PC and stage step enables
//   o_flush_if_id, o_bubble_id_ex - NOP into IF/ID, zero ID/EX control
//   o_halted, o_state           - drained-after-HALT flag, FSM state
//   o_cycle_count               - saturating count of stepped cycles
// Build option: define PIPELINE_STEP_CTRL_CYCLE_COUNT_EN to implement the
// cycle counter; otherwise o_cycle_count is tied to zero.
module pipeline_step_ctrl #(
  parameter int unsigned NB_REGS      = pipeline_ctrl_pkg::NB_REGS,
  parameter int unsigned NB_CNT       = 32,
  parameter int unsigned DRAIN_CYCLES = pipeline_ctrl_pkg::DRAIN_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_run,
  input  logic               i_step_req,
  input  logic               i_restart,
  input  logic               i_halt_decoded,
  input  logic               i_id_ex_mem_read,
  input  logic [NB_REGS-1:0] i_id_ex_rt,
  input  logic [NB_REGS-1:0] i_if_id_rs,
  input  logic [NB_REGS-1:0] i_if_id_rt,
  input  logic               i_branch_taken,
  input  logic               i_jump,
  output logic               o_pc_en,
  output logic               o_step_if_id,
  output logic               o_step_id_ex,
  output logic               o_step_ex_mem,
  output logic               o_step_mem_wb,
  output logic               o_flush_if_id,
  output logic               o_bubble_id_ex,
  output logic               o_halted,
  output logic [2:0]         o_state,
  output logic [NB_CNT-1:0]  o_cycle_count
);

  import pipeline_ctrl_pkg::*;

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               load_use;
  logic               ctrl_xfer;
  logic               stall;
  logic               active;

  hazard_detect #(
    .NB_REGS (NB_REGS)
  ) u_hazard_detect (
    .mem_read (i_id_ex_mem_read),
    .id_ex_rt (i_id_ex_rt),
    .if_id_rs (i_if_id_rs),
    .if_id_rt (i_if_id_rt),
    .stall    (load_use)
  );

  assign active    = is_active(state_q);
  assign ctrl_xfer = i_branch_taken || i_jump;
  // The flushed IF/ID instruction is discarded anyway, so its hazard is moot.
  assign stall     = load_use && !ctrl_xfer;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        // Run wins over a simultaneous step request.
        if (i_run) begin
          state_d = StRun;
        end else if (i_step_req) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (i_halt_decoded) begin
          state_d = StDrain;
          drain_d = '0;
        end else if (!i_run) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        if (i_halt_decoded) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // i_run is deliberately not consulted: a drain always completes.
        if (drain_q == DRAIN_LAST) begin
          state_d = StHalted;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StHalted: begin
        if (i_restart) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        drain_d = '0;
      end
    endcase
  end

  always_comb begin
    o_pc_en        = 1'b0;
    o_step_if_id   = 1'b0;
    o_step_id_ex   = 1'b0;
    o_step_ex_mem  = 1'b0;
    o_step_mem_wb  = 1'b0;
    o_flush_if_id  = 1'b0;
    o_bubble_id_ex = 1'b0;
    o_halted       = 1'b0;
    unique case (state_q)
      StRun, StStep: begin
        o_pc_en        = !stall;
        o_step_if_id   = !stall;
        o_step_id_ex   = 1'b1;
        o_step_ex_mem  = 1'b1;
        o_step_mem_wb  = 1'b1;
        o_flush_if_id  = ctrl_xfer;
        o_bubble_id_ex = stall;
      end
      StDrain: begin
        // PC frozen; IF/ID keeps loading NOPs behind the HALT.
        o_step_if_id   = 1'b1;
        o_step_id_ex   = 1'b1;
        o_step_ex_mem  = 1'b1;
        o_step_mem_wb  = 1'b1;
        o_flush_if_id  = 1'b1;
      end
      StHalted: begin
        o_halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_state = state_q;

`ifdef PIPELINE_STEP_CTRL_CYCLE_COUNT_EN
  logic [NB_CNT-1:0] cycle_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycle_cnt_q <= '0;
    end else if (active && !(&cycle_cnt_q)) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  assign o_cycle_count = cycle_cnt_q;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
module tb_pipeline_step_ctrl;

  localparam int NB_REGS = 5;
  localparam int NB_CNT  = 32;
  localparam int DRAIN   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, step_req = 1'b0, restart = 1'b0, halt = 1'b0;
  logic mem_read = 1'b0, br = 1'b0, jmp = 1'b0;
  logic [NB_REGS-1:0] ex_rt = '0, rs = '0, rt = '0;

  logic o_pc_en, o_step_if_id, o_step_id_ex, o_step_ex_mem, o_step_mem_wb;
  logic o_flush_if_id, o_bubble_id_ex, o_halted;
  logic [2:0] o_state;
  logic [NB_CNT-1:0] o_cycle_count;
  logic [10:0] dut_outs;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pipeline_step_ctrl #(
    .NB_REGS      (NB_REGS),
    .NB_CNT       (NB_CNT),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_run            (run),
    .i_step_req       (step_req),
    .i_restart        (restart),
    .i_halt_decoded   (halt),
    .i_id_ex_mem_read (mem_read),
    .i_id_ex_rt       (ex_rt),
    .i_if_id_rs       (rs),
    .i_if_id_rt       (rt),
    .i_branch_taken   (br),
    .i_jump           (jmp),
    .o_pc_en          (o_pc_en),
    .o_step_if_id     (o_step_if_id),
    .o_step_id_ex     (o_step_id_ex),
    .o_step_ex_mem    (o_step_ex_mem),
    .o_step_mem_wb    (o_step_mem_wb),
    .o_flush_if_id    (o_flush_if_id),
    .o_bubble_id_ex   (o_bubble_id_ex),
    .o_halted         (o_halted),
    .o_state          (o_state),
    .o_cycle_count    (o_cycle_count)
  );

  assign dut_outs = {o_pc_en, o_step_if_id, o_step_id_ex, o_step_ex_mem, o_step_mem_wb,
                     o_flush_if_id, o_bubble_id_ex, o_halted, o_state};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: mode number, drain steps still owed, stepped-cycle tally.
  int m_state = 0;
  int m_drain_left = 0;
  logic [NB_CNT-1:0] m_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_drain_left = 0;
      m_cnt = '0;
    end else begin
      if (m_state inside {1, 2, 3} && m_cnt != '1) m_cnt = m_cnt + 1;
      case (m_state)
        0: if (run) m_state = 1; else if (step_req) m_state = 2;
        1, 2: begin
          if (halt) begin
            m_state = 3;
            m_drain_left = DRAIN;
          end else if (m_state == 2 || !run) begin
            m_state = 0;
          end
        end
        3: begin
          m_drain_left--;
          if (m_drain_left == 0) m_state = 4;
        end
        4: if (restart) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  function automatic logic [10:0] exp_outs();
    logic lu, fl, st;
    lu = mem_read && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
    fl = br || jmp;
    st = lu && !fl;
    case (m_state)
      1, 2:    return {!st, !st, 3'b111, fl, st, 1'b0, 3'(m_state)};
      3:       return {1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 3'd3};
      4:       return {7'b0, 1'b1, 3'd4};
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [NB_CNT-1:0] exp_cnt();
`ifdef PIPELINE_STEP_CTRL_CYCLE_COUNT_EN
    return m_cnt;
`else
    return '0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("outs_vs_model", dut_outs, exp_outs());
      check("count_vs_model", o_cycle_count, exp_cnt());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int en_cycles;
  int drain_seen;

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("reset_outs", dut_outs, 11'd0);
    check("reset_count", o_cycle_count, 0);
    rst_n = 1'b1;
    tick();

    // Continuous run: IDLE cycle then 10 stepped cycles.
    run = 1'b1;
    repeat (11) tick();
    check("run_state", o_state, 1);
    check("run_enables", dut_outs[10:6], 5'h1f);
`ifdef PIPELINE_STEP_CTRL_CYCLE_COUNT_EN
    check("run_count10", o_cycle_count, 10);
`endif

    // Load-use on rs.
    mem_read = 1'b1; ex_rt = 5'd5; rs = 5'd5;
    #1;
    check("lu_ctrl", dut_outs[10:4], 7'b0011101);
    tick();
    ex_rt = 5'd0; rs = 5'd0;
    #1;
    check("lu_rt0_ctrl", dut_outs[10:4], 7'b1111100);
    tick();
    // Branch beats a load-use match on rt.
    ex_rt = 5'd7; rt = 5'd7; br = 1'b1;
    #1;
    check("br_over_lu", dut_outs[10:4], 7'b1111110);
    tick();
    br = 1'b0; jmp = 1'b1;
    #1;
    check("jmp_flush", o_flush_if_id, 1'b1);
    tick();
    jmp = 1'b0; mem_read = 1'b0; ex_rt = '0; rt = '0;
    run = 1'b0;
    tick();
    check("run_off_idle", o_state, 0);

    // Single step, from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    en_cycles = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (o_step_ex_mem) en_cycles++;
        tick();
      end
    end
    check("step_en_cycles", en_cycles, 3);
`ifdef PIPELINE_STEP_CTRL_CYCLE_COUNT_EN
    check("step_count3", o_cycle_count, 3);
`endif

    // Run wins over step.
    run = 1'b1; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("run_wins", o_state, 1);

    // HALT drain; dropping run mid-drain must not abort it.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int c = 0; c < DRAIN; c++) begin
      check("drain_ctrl", {o_state, o_pc_en, o_flush_if_id}, {3'd3, 1'b0, 1'b1});
      if (c == 0) run = 1'b0;
      tick();
    end
    check("halted_state", o_state, 4);
    check("halted_outs", dut_outs[10:3], 8'b00000001);
    run = 1'b1; step_req = 1'b1;
    tick();
    run = 1'b0; step_req = 1'b0;
    check("halted_ignores_run", o_state, 4);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_idle", o_state, 0);

    // Reset during the second drain cycle.
    run = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_drain_outs", dut_outs, 11'd0);
    check("rst_mid_drain_count", o_cycle_count, 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst", {o_state, o_halted}, 4'd0);

    // A later drain must last the full length (drain counter was cleared).
    run = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    drain_seen = 0;
    for (int c = 0; c < 10 && !o_halted; c++) begin
      if (o_state == 3'd3) drain_seen++;
      tick();
    end
    check("drain_len_after_rst", drain_seen, DRAIN);
    check("halted_after_drain", o_halted, 1'b1);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
